// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the memory arbiter slice.
// Holds the arbiter FSM state encoding, the default memory latency and block
// size, and the 16-bit word/address types used on every memory-side port.
package mem_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEF   = 4;  // cycles from read issue to data return
  localparam int unsigned BLK_WORDS_DEF = 8;  // 16-bit words per cache block

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_fill_counter.sv
// arb_fill_counter: issue and return word counters for one block fill.
// Both counters wrap at BLK_WORDS; issue_done latches once the last read has
// gone out so no further reads are issued, ret_last flags the final return.
module arb_fill_counter #(
  parameter int unsigned BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         issue,
  input  logic                         ret,
  output logic [$clog2(BLK_WORDS)-1:0] issue_cnt,
  output logic [$clog2(BLK_WORDS)-1:0] ret_cnt,
  output logic                         issue_done,
  output logic                         ret_last
);

  localparam int unsigned          CW   = $clog2(BLK_WORDS);
  localparam logic [CW-1:0]        LAST = CW'(BLK_WORDS - 1);

  // Count issued reads and returned words; clear between operations.
  // NOTE: reset is sampled only at the clock edge (synchronous), so it lives inside the posedge block.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      if (issue && !issue_done) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (issue_cnt == LAST) issue_done <= 1'b1;
      end
      if (ret) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  assign ret_last = (ret_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I-cache fills, D-cache fills and D-cache
// write-through stores onto one main-memory port.
// Build option: define ARB_RR_EN to alternate ic/dc miss priority
// (round-robin); stores always win. Undefined gives fixed dc-over-ic priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
  parameter int unsigned BLK_WORDS = BLK_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ic_miss,
  input  addr_t                        ic_miss_addr,
  input  logic                         dc_miss,
  input  addr_t                        dc_miss_addr,
  input  logic                         dc_wr_req,
  input  addr_t                        dc_wr_addr,
  input  word_t                        dc_wr_data,
  output logic                         mem_en,
  output logic                         mem_wr,
  output addr_t                        mem_addr,
  output word_t                        mem_wdata,
  input  word_t                        mem_rdata,
  input  logic                         mem_data_valid,
  output logic                         ic_fill_valid,
  output logic                         dc_fill_valid,
  output word_t                        fill_data,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic                         ic_fill_done,
  output logic                         dc_fill_done,
  output logic                         dc_wr_ack
);

  localparam int unsigned CW = $clog2(BLK_WORDS);

  // Fill addressing needs a power-of-two block and a latency of at least one cycle.
  if (MEM_LAT == 0 || BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_bad_params
    $error("mem_arbiter: MEM_LAT must be >0 and BLK_WORDS a power of two >= 2");
  end

  arb_state_e    state_q, state_d;
  addr_t         miss_addr_q, miss_addr_d;
  logic          in_fill, issue, ret, dc_wins;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic          issue_done, ret_last;
  logic          unused_low_bits;

  assign in_fill = (state_q == IFILL) || (state_q == DFILL);

  // Word offset bits of the miss address are regenerated from the issue counter.
  assign unused_low_bits = ^miss_addr_q[CW:0];

  arb_fill_counter #(.BLK_WORDS(BLK_WORDS)) u_fill_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!in_fill),
    .issue      (issue),
    .ret        (ret),
    .issue_cnt  (issue_cnt),
    .ret_cnt    (ret_cnt),
    .issue_done (issue_done),
    .ret_last   (ret_last)
  );

`ifdef ARB_RR_EN
  logic last_dc_q;

  // Remember which miss side won last so it loses the next ic/dc tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_dc_q <= 1'b0;
    end else if (state_q == IDLE && state_d == DFILL) begin
      last_dc_q <= 1'b1;
    end else if (state_q == IDLE && state_d == IFILL) begin
      last_dc_q <= 1'b0;
    end
  end

  assign dc_wins = !last_dc_q;
`else
  assign dc_wins = 1'b1;
`endif

  // State and latched miss address register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Grant decision in IDLE, read issue/return steering in fills, single-cycle store.
  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    issue         = 1'b0;
    ret           = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    ic_fill_valid = 1'b0;
    dc_fill_valid = 1'b0;
    fill_data     = '0;
    fill_word     = '0;
    ic_fill_done  = 1'b0;
    dc_fill_done  = 1'b0;
    dc_wr_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dc_wr_req) begin
          state_d = DWRITE;
        end else if (dc_miss && (!ic_miss || dc_wins)) begin
          state_d     = DFILL;
          miss_addr_d = dc_miss_addr;
        end else if (ic_miss) begin
          state_d     = IFILL;
          miss_addr_d = ic_miss_addr;
        end
      end

      IFILL, DFILL: begin
        if (!issue_done) begin
          issue    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = {miss_addr_q[15:CW+1], issue_cnt, 1'b0};
        end
        if (mem_data_valid) begin
          ret       = 1'b1;
          fill_data = mem_rdata;
          fill_word = ret_cnt;
          if (state_q == IFILL) ic_fill_valid = 1'b1;
          else                  dc_fill_valid = 1'b1;
          if (ret_last) begin
            if (state_q == IFILL) ic_fill_done = 1'b1;
            else                  dc_fill_done = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DWRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dc_wr_addr;
        mem_wdata = dc_wr_data;
        dc_wr_ack = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model that expands each grant into its expected cycle
// schedule. A fixed-latency memory model answers every issued read.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LAT = MEM_LAT_DEF;
  localparam int unsigned BLK = BLK_WORDS_DEF;
  localparam int          CW  = $clog2(BLK);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_miss, dc_miss, dc_wr_req;
  addr_t         ic_miss_addr, dc_miss_addr, dc_wr_addr;
  word_t         dc_wr_data;
  logic          mem_en, mem_wr;
  addr_t         mem_addr;
  word_t         mem_wdata, mem_rdata;
  logic          mem_data_valid;
  logic          ic_fill_valid, dc_fill_valid;
  word_t         fill_data;
  logic [CW-1:0] fill_word;
  logic          ic_fill_done, dc_fill_done, dc_wr_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(BLK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_miss        (ic_miss),
    .ic_miss_addr   (ic_miss_addr),
    .dc_miss        (dc_miss),
    .dc_miss_addr   (dc_miss_addr),
    .dc_wr_req      (dc_wr_req),
    .dc_wr_addr     (dc_wr_addr),
    .dc_wr_data     (dc_wr_data),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid),
    .ic_fill_valid  (ic_fill_valid),
    .dc_fill_valid  (dc_fill_valid),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .ic_fill_done   (ic_fill_done),
    .dc_fill_done   (dc_fill_done),
    .dc_wr_ack      (dc_wr_ack)
  );

  // Memory contents as a fixed scramble of the word address.
  function automatic word_t mem_fn(input addr_t a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Fixed-latency read pipe: {valid, addr}; stray returns can be injected on top.
  logic [16:0] pipe [LAT];
  logic        mem_clr;
  logic        stray_v;
  word_t       stray_d;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {mem_en && !mem_wr, mem_addr};
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem_data_valid = pipe[LAT-1][16] | stray_v;
  assign mem_rdata      = pipe[LAT-1][16] ? mem_fn(pipe[LAT-1][15:0]) : stray_d;

  // One cycle of expected (or observed) outputs.
  typedef struct packed {
    logic          is_fill;
    logic          en;
    logic          wr;
    addr_t         addr;
    word_t         wdata;
    logic          icv;
    logic          dcv;
    word_t         data;
    logic [CW-1:0] word;
    logic          icd;
    logic          dcd;
    logic          ack;
  } cyc_t;

  cyc_t  q[$];
  cyc_t  hist[$];
  cyc_t  cur, prev;
  logic  m_last_dc;
  int    active_side;
  int    holdoff;
  bit    rand_on, rst_req;
  logic  ic_pend, dc_pend, wr_pend;
  addr_t ic_a, dc_a, wr_a;
  word_t wr_d;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [63:0] outs(input cyc_t r);
    return 64'({r.en, r.wr, r.addr, r.wdata, r.icv, r.dcv, r.data, r.word, r.icd, r.dcd, r.ack});
  endfunction

  function automatic logic dc_wins_tie();
`ifdef ARB_RR_EN
    return !m_last_dc;
`else
    return 1'b1;
`endif
  endfunction

  // Expand a granted fill into its BLK+LAT cycle schedule.
  task automatic push_fill(input logic to_dc, input addr_t a);
    addr_t base;
    base = a & ~addr_t'(2 * BLK - 1);
    for (int c = 0; c < int'(BLK + LAT); c++) begin
      cyc_t r;
      r = '0;
      r.is_fill = 1'b1;
      if (c < int'(BLK)) begin
        r.en   = 1'b1;
        r.addr = base | addr_t'(2 * c);
      end
      if (c >= int'(LAT)) begin
        int k;
        k      = c - int'(LAT);
        r.data = mem_fn(base | addr_t'(2 * k));
        r.word = CW'(k);
        if (to_dc) r.dcv = 1'b1; else r.icv = 1'b1;
        if (k == int'(BLK) - 1) begin
          if (to_dc) r.dcd = 1'b1; else r.icd = 1'b1;
        end
      end
      q.push_back(r);
    end
  endtask

  // Idle cycle: decide the grant from current requests; otherwise replay schedule.
  task automatic model_cycle();
    if (q.size() == 0) begin
      cur         = '0;
      active_side = 0;
      if (dc_wr_req) begin
        cyc_t r;
        r       = '0;
        r.en    = 1'b1;
        r.wr    = 1'b1;
        r.addr  = dc_wr_addr;
        r.wdata = dc_wr_data;
        r.ack   = 1'b1;
        q.push_back(r);
      end else if (dc_miss || ic_miss) begin
        logic to_dc;
        to_dc = dc_miss && (!ic_miss || dc_wins_tie());
        push_fill(to_dc, to_dc ? dc_miss_addr : ic_miss_addr);
        m_last_dc   = to_dc;
        active_side = to_dc ? 2 : 1;
      end
    end else begin
      cur = q.pop_front();
    end
  endtask

  // One clock: drive requests, compute expectation, compare mid-cycle.
  task automatic step();
    cyc_t o;
    @(posedge clk);
    #1;
    if (prev.icd) ic_pend = 1'b0;
    if (prev.dcd) dc_pend = 1'b0;
    if (prev.ack) wr_pend = 1'b0;
    if (holdoff > 0) begin
      holdoff--;
    end else if (rand_on) begin
      if (!ic_pend && $urandom_range(0, 5) == 0) begin ic_pend = 1'b1; ic_a = addr_t'($urandom); end
      if (!dc_pend && $urandom_range(0, 5) == 0) begin dc_pend = 1'b1; dc_a = addr_t'($urandom); end
      if (!wr_pend && $urandom_range(0, 7) == 0) begin
        wr_pend = 1'b1; wr_a = addr_t'($urandom); wr_d = word_t'($urandom);
      end
      if (q.size() != 0 && active_side == 1 && ic_pend) ic_a = addr_t'($urandom);
      if (q.size() != 0 && active_side == 2 && dc_pend) dc_a = addr_t'($urandom);
      if ($urandom_range(0, 299) == 0) rst_req = 1'b1;
    end
    rst_n        = !rst_req;
    ic_miss      = ic_pend;
    ic_miss_addr = ic_a;
    dc_miss      = dc_pend;
    dc_miss_addr = dc_a;
    dc_wr_req    = wr_pend;
    dc_wr_addr   = wr_a;
    dc_wr_data   = wr_d;
    model_cycle();
    stray_v = 1'b0;
    stray_d = '0;
    if (rand_on && !cur.is_fill && !pipe[LAT-1][16] && $urandom_range(0, 3) == 0) begin
      stray_v = 1'b1;
      stray_d = word_t'($urandom);
    end
    if (rst_req) begin
      q.delete();
      m_last_dc   = 1'b0;
      active_side = 0;
      ic_pend     = 1'b0;
      dc_pend     = 1'b0;
      wr_pend     = 1'b0;
      holdoff     = int'(LAT) + 2;
      rst_req     = 1'b0;
    end
    @(negedge clk);
    o       = '0;
    o.en    = mem_en;    o.wr    = mem_wr;    o.addr = mem_addr; o.wdata = mem_wdata;
    o.icv   = ic_fill_valid; o.dcv = dc_fill_valid; o.data = fill_data; o.word = fill_word;
    o.icd   = ic_fill_done;  o.dcd = dc_fill_done;  o.ack  = dc_wr_ack;
    hist.push_back(o);
    check("mem",  64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({cur.en, cur.wr, cur.addr, cur.wdata}));
    check("fill", 64'({ic_fill_valid, dc_fill_valid, fill_data, fill_word}),
                  64'({cur.icv, cur.dcv, cur.data, cur.word}));
    check("done", 64'({ic_fill_done, dc_fill_done, dc_wr_ack}), 64'({cur.icd, cur.dcd, cur.ack}));
    prev = cur;
  endtask

  // Reset pulse followed by enough quiet cycles to drain any in-flight returns.
  task automatic settle();
    rand_on = 1'b0;
    rst_req = 1'b1;
    step();
    repeat (int'(LAT) + 2) step();
    hist.delete();
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1; stray_v = 1'b0; stray_d = '0;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
    ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    ic_pend = 1'b0; dc_pend = 1'b0; wr_pend = 1'b0;
    ic_a = '0; dc_a = '0; wr_a = '0; wr_d = '0;
    prev = '0; cur = '0; m_last_dc = 1'b0; active_side = 0; holdoff = 0;
    rand_on = 1'b0; rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;

    // Out of reset: everything quiet.
    hist.delete();
    step();
    check("rst_outputs", outs(hist[0]), 64'd0);

    // I-cache miss at 0x1236: reads cycles 1-8, returns 5-12, done 12, idle 13.
    settle();
    ic_pend = 1'b1; ic_a = 16'h1236;
    repeat (14) step();
    check("ifill_rd_first", 64'({hist[1].en, hist[1].addr}), 64'({1'b1, 16'h1230}));
    check("ifill_rd_last",  64'({hist[8].en, hist[8].addr}), 64'({1'b1, 16'h123E}));
    check("ifill_rd_stop",  64'(hist[9].en), 64'd0);
    check("ifill_no_early", 64'(hist[4].icv), 64'd0);
    check("ifill_w0",       64'({hist[5].icv, hist[5].word, hist[5].data}),
                            64'({1'b1, CW'(0), mem_fn(16'h1230)}));
    check("ifill_last",     64'({hist[12].icv, hist[12].word, hist[12].icd}),
                            64'({1'b1, CW'(BLK - 1), 1'b1}));
    check("ifill_not_done", 64'(hist[11].icd), 64'd0);
    check("ifill_idle",     outs(hist[13]), 64'd0);

    // ic and dc miss together: DFILL first, IFILL right after one idle cycle.
    settle();
    ic_pend = 1'b1; ic_a = 16'h1236;
    dc_pend = 1'b1; dc_a = 16'h4A5C;
    repeat (28) step();
    check("pair_dc_first",  64'(hist[1].addr), 64'h4A50);
    check("pair_dc_done",   64'({hist[12].dcd, hist[12].icd}), 64'({1'b1, 1'b0}));
    check("pair_gap",       outs(hist[13]), 64'd0);
    check("pair_ic_second", 64'(hist[14].addr), 64'h1230);
    check("pair_ic_done",   64'(hist[25].icd), 64'd1);

    // Store beats a simultaneous miss and lasts one cycle.
    settle();
    wr_pend = 1'b1; wr_a = 16'h0040; wr_d = 16'hBEEF;
    dc_pend = 1'b1; dc_a = 16'h0100;
    repeat (16) step();
    check("wr_cycle",  64'({hist[1].en, hist[1].wr, hist[1].addr, hist[1].wdata, hist[1].ack}),
                       64'({1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1}));
    check("wr_gap",    outs(hist[2]), 64'd0);
    check("wr_dfill",  64'({hist[3].en, hist[3].wr, hist[3].addr}), 64'({1'b1, 1'b0, 16'h0100}));
    check("wr_ddone",  64'(hist[14].dcd), 64'd1);

    // Reset during DFILL: no done, quiet outputs while late returns arrive.
    settle();
    dc_pend = 1'b1; dc_a = 16'h0300;
    for (int c = 0; c < 15; c++) begin
      if (c == 6) rst_req = 1'b1;
      step();
    end
    check("rst_fill_pre", 64'({hist[6].dcv, hist[6].word}), 64'({1'b1, CW'(1)}));
    for (int c = 7; c < 15; c++) check("rst_fill_quiet", outs(hist[c]), 64'd0);

    // Miss dropped mid-fill still completes.
    settle();
    ic_pend = 1'b1; ic_a = 16'h1236;
    for (int c = 0; c < 14; c++) begin
      if (c == 3) ic_pend = 1'b0;
      step();
    end
    check("drop_w5",   64'({hist[10].icv, hist[10].word}), 64'({1'b1, CW'(5)}));
    check("drop_done", 64'(hist[12].icd), 64'd1);
    check("drop_idle", outs(hist[13]), 64'd0);

    // Randomized traffic, stray returns, occasional resets.
    settle();
    rand_on = 1'b1;
    repeat (3000) step();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
